relu_grad_unit: RTL

- Backward-direction companion to the nonlinear (ReLU) unit.
- During the forward pass it snoops each pre-activation value and records a 1-bit derivative mask in an internal bit-FIFO.
- During the backward pass it accepts incoming gradients and replays the masks in the same element order. It emits the gradient where the forward input was positive, and zero otherwise.
- Sits beside the nonlinear unit, between the output buffer and the gradient write-back path.

---
 rtl/relu_grad_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/relu_grad_unit.sv
// ReLU backward unit: records a derivative bit per forward element and masks returning gradients in order.
// Optional leaky-gradient path selected by defining RELU_LEAKY_GRAD_EN.
module relu_grad_unit #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int LEAK_SHIFT = 3,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              fwd_valid,
  input  logic [WIDTH-1:0]  fwd_in,
  output logic              fwd_ready,
  input  logic              bwd_in_valid,
  input  logic [WIDTH-1:0]  bwd_grad,
  output logic              bwd_in_ready,
  output logic              bwd_out_valid,
  output logic [WIDTH-1:0]  bwd_out,
  input  logic              bwd_out_ready,
  output logic [AW:0]       mask_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FWD, BWD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DEPTH-1:0]  r_mask;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_out_vld;
  logic [WIDTH-1:0]  r_out;
  logic              w_fwd_acc;
  logic              w_bwd_acc;
  logic              w_fwd_mask;
  logic              w_rd_mask;
  logic              w_full;
  logic              w_empty;
  logic              w_last;

  function automatic logic [WIDTH-1:0] f_mask_grad(input logic m, input logic signed [WIDTH-1:0] g);
    logic [WIDTH-1:0] res;
    if (m) begin
      res = g;
    end else begin
`ifdef RELU_LEAKY_GRAD_EN
      res = g >>> LEAK_SHIFT;
`else
      res = '0;
`endif
    end
    return res;
  endfunction

`ifndef RELU_LEAKY_GRAD_EN
  logic w_unused_leak;
  assign w_unused_leak = (LEAK_SHIFT != 0);
`endif

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign w_full     = r_count[AW];
  assign w_empty    = (r_count == '0);
  assign w_last     = (r_count == (AW+1)'(1));
  assign w_fwd_mask = !fwd_in[WIDTH-1] && (fwd_in != '0);
  assign w_rd_mask  = r_mask[r_rd_ptr];

  assign fwd_ready    = (r_state != BWD) && !w_full && !((r_state == FWD) && bwd_in_valid);
  assign bwd_in_ready = (r_state != IDLE) && !w_empty && (!r_out_vld || bwd_out_ready);
  assign w_fwd_acc    = fwd_valid && fwd_ready;
  assign w_bwd_acc    = bwd_in_valid && bwd_in_ready;

  assign bwd_out_valid = r_out_vld;
  assign bwd_out       = r_out;
  assign mask_count    = r_count;
  assign busy          = (r_state != IDLE) || r_out_vld;

  // Draining the final mask from FWD returns straight to IDLE so no state can strand at count 0.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_fwd_acc) w_state_nxt = FWD;
      FWD:  if (w_bwd_acc) w_state_nxt = w_last ? IDLE : BWD;
      BWD:  if (w_bwd_acc && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else if (clear) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fwd_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_count  <= r_count + (AW+1)'(1);
      end else if (w_bwd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count  <= r_count - (AW+1)'(1);
      end
      if (w_bwd_acc) begin
        r_out_vld <= 1'b1;
        r_out     <= f_mask_grad(w_rd_mask, bwd_grad);
      end else if (bwd_out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fwd_acc && !clear) r_mask[r_wr_ptr] <= w_fwd_mask;
  end

endmodule
